// File: rtl/controle_rega.sv
`default_nettype none
// ============================================================================
// Module      : controle_rega
// Description : Irrigation sequencing controller. Picks sprinkler or drip,
//               times irrigation and cleaning cycles, latches error state.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_rega #(
    parameter int T_ASP  = 10,
    parameter int T_GOT  = 20,
    parameter int T_LIMP = 5,
    parameter int CW     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       solo_seco,
    input  logic       modo_got,
    input  logic       nivel_baixo,
    input  logic       pedido_limpeza,
    input  logic       erro_valida,
    input  logic       reconhece,
    output logic [1:0] mef1,
    output logic       asp,
    output logic       got,
    output logic       limpeza,
    output logic       alarme,
    output logic       fim_rega
);

    localparam logic [1:0] c_ocioso  = 2'b00;
    localparam logic [1:0] c_limpeza = 2'b01;
    localparam logic [1:0] c_erro    = 2'b10;
    localparam logic [1:0] c_rega    = 2'b11;

    // Timers count down to zero, so the load value is length minus one.
    localparam logic [CW-1:0] c_t_asp  = CW'(T_ASP - 1);
    localparam logic [CW-1:0] c_t_got  = CW'(T_GOT - 1);
    localparam logic [CW-1:0] c_t_limp = CW'(T_LIMP - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_timer;
    logic          r_tipo;
    logic          r_pendente;
    logic          r_asp;
    logic          r_got;
    logic          r_limpeza;
    logic          r_alarme;
    logic          r_fim_rega;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_timer_nxt;
    logic          w_tipo_nxt;
    logic          w_pendente_nxt;
    logic          w_fim_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_tipo_nxt  = r_tipo;
        w_fim_nxt   = 1'b0;
        case (r_state)
            c_ocioso: begin
                if (nivel_baixo | erro_valida) begin
                    w_state_nxt = c_erro;
                end else if (pedido_limpeza | r_pendente) begin
                    w_state_nxt = c_limpeza;
                    w_timer_nxt = c_t_limp;
                end else if (solo_seco) begin
                    w_state_nxt = c_rega;
                    w_tipo_nxt  = modo_got;
                    w_timer_nxt = modo_got ? c_t_got : c_t_asp;
                end
            end
            c_rega: begin
                // Abort wins over a run that would end on this same edge.
                if (nivel_baixo | erro_valida) begin
                    w_state_nxt = c_erro;
                end else if (r_timer == '0) begin
                    w_state_nxt = c_ocioso;
                    w_fim_nxt   = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - CW'(1);
                end
            end
            c_limpeza: begin
                if (nivel_baixo) begin
                    w_state_nxt = c_erro;
                end else if (r_timer == '0) begin
                    w_state_nxt = c_ocioso;
                end else begin
                    w_timer_nxt = r_timer - CW'(1);
                end
            end
            c_erro: begin
                if (reconhece & ~nivel_baixo & ~erro_valida) begin
                    w_state_nxt = c_ocioso;
                end
            end
            default: w_state_nxt = c_ocioso;
        endcase
    end

    // Entering cleaning consumes the request, even one arriving that cycle.
    always_comb begin
        w_pendente_nxt = r_pendente;
        if ((r_state != c_limpeza) && (w_state_nxt == c_limpeza)) begin
            w_pendente_nxt = 1'b0;
        end else if (pedido_limpeza && (r_state != c_limpeza)) begin
            w_pendente_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ocioso;
            r_timer    <= '0;
            r_tipo     <= 1'b0;
            r_pendente <= 1'b0;
            r_asp      <= 1'b0;
            r_got      <= 1'b0;
            r_limpeza  <= 1'b0;
            r_alarme   <= 1'b0;
            r_fim_rega <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_tipo     <= w_tipo_nxt;
            r_pendente <= w_pendente_nxt;
            r_asp      <= (w_state_nxt == c_rega) & ~w_tipo_nxt;
            r_got      <= (w_state_nxt == c_rega) &  w_tipo_nxt;
            r_limpeza  <= (w_state_nxt == c_limpeza);
            r_alarme   <= (w_state_nxt == c_erro);
            r_fim_rega <= w_fim_nxt;
        end
    end

    assign mef1     = r_state;
    assign asp      = r_asp;
    assign got      = r_got;
    assign limpeza  = r_limpeza;
    assign alarme   = r_alarme;
    assign fim_rega = r_fim_rega;

endmodule
`default_nettype wire

// File: tb/tb_controle_rega.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_rega
// Description : Directed self-checking bench for controle_rega.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_rega;

    // Observed vector: {mef1[1:0], asp, got, limpeza, alarme, fim_rega}
    localparam logic [6:0] c_idle = 7'b00_00000;
    localparam logic [6:0] c_fim  = 7'b00_00001;
    localparam logic [6:0] c_rasp = 7'b11_10000;
    localparam logic [6:0] c_rgot = 7'b11_01000;
    localparam logic [6:0] c_limp = 7'b01_00100;
    localparam logic [6:0] c_err  = 7'b10_00010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       solo_seco = 1'b0;
    logic       modo_got = 1'b0;
    logic       nivel_baixo = 1'b0;
    logic       pedido_limpeza = 1'b0;
    logic       erro_valida = 1'b0;
    logic       reconhece = 1'b0;
    logic [1:0] mef1;
    logic       asp;
    logic       got;
    logic       limpeza;
    logic       alarme;
    logic       fim_rega;
    logic [6:0] w_obs;

    int n_checks = 0;
    int n_errors = 0;

    controle_rega #(.T_ASP(10), .T_GOT(20), .T_LIMP(5), .CW(8)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .solo_seco      (solo_seco),
        .modo_got       (modo_got),
        .nivel_baixo    (nivel_baixo),
        .pedido_limpeza (pedido_limpeza),
        .erro_valida    (erro_valida),
        .reconhece      (reconhece),
        .mef1           (mef1),
        .asp            (asp),
        .got            (got),
        .limpeza        (limpeza),
        .alarme         (alarme),
        .fim_rega       (fim_rega)
    );

    always #5 clk = ~clk;

    assign w_obs = {mef1, asp, got, limpeza, alarme, fim_rega};

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%b exp=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_run(input string tag, input logic [6:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, w_obs, code);
            step(1);
        end
    endtask

    initial begin
        #1;
        check("reset_async", w_obs, c_idle);
        step(2);
        check("reset_held", w_obs, c_idle);
        reset = 1'b0;
        step(1);
        check("idle_after_reset", w_obs, c_idle);

        // 1: single sprinkler run of 10 cycles, then fim_rega pulse
        solo_seco = 1'b1; modo_got = 1'b0;
        step(1);
        solo_seco = 1'b0;
        expect_run("t1_asp", c_rasp, 10);
        check("t1_fim", w_obs, c_fim);
        step(1);
        check("t1_idle", w_obs, c_idle);

        // 2: drip run with mode toggling mid-run, back-to-back restart as asp
        solo_seco = 1'b1; modo_got = 1'b1;
        step(1);
        expect_run("t2_got_a", c_rgot, 5);
        modo_got = 1'b0;
        expect_run("t2_got_b", c_rgot, 15);
        check("t2_fim", w_obs, c_fim);
        step(1);
        solo_seco = 1'b0;
        expect_run("t2_asp2", c_rasp, 10);
        check("t2_fim2", w_obs, c_fim);
        step(1);
        check("t2_idle", w_obs, c_idle);

        // 3: cleaning request during a run is deferred until the run ends
        solo_seco = 1'b1; modo_got = 1'b0;
        step(1);
        solo_seco = 1'b0;
        expect_run("t3_asp_a", c_rasp, 2);
        pedido_limpeza = 1'b1;
        expect_run("t3_asp_req", c_rasp, 1);
        pedido_limpeza = 1'b0;
        expect_run("t3_asp_b", c_rasp, 7);
        check("t3_fim", w_obs, c_fim);
        step(1);
        expect_run("t3_limp", c_limp, 5);
        expect_run("t3_idle", c_idle, 2);

        // 4: low water aborts a drip run; acknowledge only without a fault
        solo_seco = 1'b1; modo_got = 1'b1;
        step(1);
        solo_seco = 1'b0;
        expect_run("t4_got", c_rgot, 3);
        nivel_baixo = 1'b1;
        expect_run("t4_got_last", c_rgot, 1);
        check("t4_err", w_obs, c_err);
        reconhece = 1'b1;
        step(1);
        check("t4_ack_ignored", w_obs, c_err);
        reconhece = 1'b0; nivel_baixo = 1'b0;
        step(1);
        check("t4_not_latched", w_obs, c_err);
        reconhece = 1'b1;
        step(1);
        check("t4_ack", w_obs, c_idle);
        reconhece = 1'b0;
        step(1);
        check("t4_idle", w_obs, c_idle);

        // 5: cleaning beats irrigation; erro_valida ignored while cleaning
        modo_got = 1'b0; pedido_limpeza = 1'b1; solo_seco = 1'b1;
        step(1);
        pedido_limpeza = 1'b0;
        expect_run("t5_limp_a", c_limp, 2);
        erro_valida = 1'b1;
        expect_run("t5_limp_err", c_limp, 2);
        erro_valida = 1'b0;
        expect_run("t5_limp_b", c_limp, 1);
        check("t5_gap", w_obs, c_idle);
        step(1);
        solo_seco = 1'b0;
        expect_run("t5_asp", c_rasp, 10);
        check("t5_fim", w_obs, c_fim);
        step(1);

        // 6: async reset mid-run clears outputs and the pending request
        solo_seco = 1'b1; modo_got = 1'b0;
        step(1);
        solo_seco = 1'b0; pedido_limpeza = 1'b1;
        step(1);
        pedido_limpeza = 1'b0;
        step(2);
        check("t6_running", w_obs, c_rasp);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_drop", w_obs, c_idle);
        step(1);
        reset = 1'b0;
        step(1);
        expect_run("t6_no_pending", c_idle, 6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
